// File: rtl/irq_aggregator.sv
// Interrupt aggregator: latches raw device requests per source as level or edge,
// masks and priority-encodes them for CP0, and tracks an IACK/EOI service window.
module irq_aggregator #(
  parameter int                N_SRC        = 6,
  parameter logic [N_SRC-1:0]  EDGE_DEFAULT = '0
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [1:0]        ADD_I,
  input  logic              WE_I,
  input  logic [3:0]        BE,
  input  logic [31:0]       DAT_I,
  output logic [31:0]       DAT_O,
  input  logic [N_SRC-1:0]  IRQ_SRC,
  input  logic              IACK_I,
  output logic [N_SRC-1:0]  HWINT,
  output logic              IRQ,
  output logic [2:0]        IRQ_ID
);

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         id_q, id_d;
  logic [N_SRC-1:0]   sync_q, prev_q;
  logic [N_SRC-1:0]   pend_q, pend_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [N_SRC-1:0]   mode_q, mode_d;

  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   w1c_clr;
  logic [N_SRC-1:0]   iack_clr;
  logic [2:0]         enc_id;
  logic               wr_en;
  logic               iack_take;
  logic               eoi;

  logic unused_bits;
  assign unused_bits = ^{BE[3:1], DAT_I[31:N_SRC]};

  assign wr_en     = WE_I && BE[0];
  assign rise      = sync_q & ~prev_q;
  assign HWINT     = pend_q & mask_q;
  assign iack_take = (state_q == IDLE) && IACK_I && (|HWINT);
  assign eoi       = wr_en && (ADD_I == 2'd3);
  assign w1c_clr   = (wr_en && (ADD_I == 2'd0)) ? DAT_I[N_SRC-1:0] : '0;

  // Lowest-numbered pending source has the highest priority.
  always_comb begin
    enc_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (HWINT[i]) enc_id = 3'(i);
    end
  end

  always_comb begin
    iack_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      iack_clr[i] = iack_take && (enc_id == 3'(i));
    end
  end

  // Level sources track sync; edge sources latch a rise, and set beats clear.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!mode_q[i])  pend_d[i] = sync_q[i];
      else             pend_d[i] = rise[i] | (pend_q[i] & ~(w1c_clr[i] | iack_clr[i]));
    end
  end

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr_en && (ADD_I == 2'd1)) mask_d = DAT_I[N_SRC-1:0];
    if (wr_en && (ADD_I == 2'd2)) mode_d = DAT_I[N_SRC-1:0];
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (iack_take) begin
          state_d = SERVICE;
          id_d    = enc_id;
        end
      end
      SERVICE: begin
        if (eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      id_q    <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= EDGE_DEFAULT;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      sync_q  <= IRQ_SRC;
      prev_q  <= sync_q;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
    end
  end

  // While in service the reported ID is frozen at the acknowledged source.
  assign IRQ    = (|HWINT) && (state_q == IDLE);
  assign IRQ_ID = (state_q == SERVICE) ? id_q : enc_id;

  always_comb begin
    DAT_O = '0;
    case (ADD_I)
      2'd0: DAT_O[N_SRC-1:0] = pend_q;
      2'd1: DAT_O[N_SRC-1:0] = mask_q;
      2'd2: DAT_O[N_SRC-1:0] = mode_q;
      default: begin
        DAT_O[9]   = (state_q == SERVICE);
        DAT_O[8]   = |HWINT;
        DAT_O[2:0] = IRQ_ID;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_aggregator.sv
// Bench for irq_aggregator: directed scenarios then random traffic, all
// checked every cycle against a per-source behavioural model.
module tb_irq_aggregator;

  localparam int N = 6;
  localparam logic [N-1:0] ED = 6'b0;

  logic          CLK_I;
  logic          RST_I;
  logic [1:0]    ADD_I;
  logic          WE_I;
  logic [3:0]    BE;
  logic [31:0]   DAT_I;
  logic [31:0]   DAT_O;
  logic [N-1:0]  IRQ_SRC;
  logic          IACK_I;
  logic [N-1:0]  HWINT;
  logic          IRQ;
  logic [2:0]    IRQ_ID;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  irq_aggregator #(.N_SRC(N), .EDGE_DEFAULT(ED)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .ADD_I(ADD_I), .WE_I(WE_I), .BE(BE),
    .DAT_I(DAT_I), .DAT_O(DAT_O), .IRQ_SRC(IRQ_SRC), .IACK_I(IACK_I),
    .HWINT(HWINT), .IRQ(IRQ), .IRQ_ID(IRQ_ID)
  );

  // clock / reset
  initial begin
    CLK_I = 1'b0;
    forever #5 CLK_I = ~CLK_I;
  end

  // reference model: one flag per source
  bit m_pend [N];
  bit m_mask [N];
  bit m_mode [N];
  bit m_sync [N];
  bit m_prev [N];
  bit m_svc;
  int m_id;

  function automatic logic [N-1:0] pack(input bit a [N]);
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_hwint();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_pend[i] && m_mask[i];
    return v;
  endfunction

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [2:0] exp_id();
    if (m_svc) return 3'(m_id);
    return 3'(lowest(exp_hwint()));
  endfunction

  function automatic logic exp_irq();
    return !m_svc && (exp_hwint() != 0);
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0: return 32'(pack(m_pend));
      2'd1: return 32'(pack(m_mask));
      2'd2: return 32'(pack(m_mode));
      default: return (32'(m_svc) << 9) | (32'(exp_hwint() != 0) << 8) | 32'(exp_id());
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [N-1:0] hw;
    bit take, wr, rise, clr;
    int tid;
    if (RST_I) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_mask[i] = 0; m_mode[i] = ED[i]; m_sync[i] = 0; m_prev[i] = 0;
      end
      m_svc = 0;
      m_id  = 0;
      return;
    end
    hw   = exp_hwint();
    take = !m_svc && IACK_I && (hw != 0);
    tid  = lowest(hw);
    wr   = WE_I && BE[0];
    for (int i = 0; i < N; i++) begin
      rise = m_sync[i] && !m_prev[i];
      clr  = (wr && ADD_I == 2'd0 && DAT_I[i]) || (take && tid == i);
      if (!m_mode[i])  m_pend[i] = m_sync[i];
      else if (rise)   m_pend[i] = 1;
      else if (clr)    m_pend[i] = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (wr && ADD_I == 2'd1) m_mask[i] = DAT_I[i];
      if (wr && ADD_I == 2'd2) m_mode[i] = DAT_I[i];
      m_prev[i] = m_sync[i];
      m_sync[i] = IRQ_SRC[i];
    end
    if (m_svc && wr && ADD_I == 2'd3) m_svc = 0;
    else if (take) begin
      m_svc = 1;
      m_id  = tid;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("hwint", 32'(HWINT), 32'(exp_hwint()));
    check("irq", 32'(IRQ), 32'(exp_irq()));
    check("irq_id", 32'(IRQ_ID), 32'(exp_id()));
    check("dat_o", DAT_O, model_read(ADD_I));
  endtask

  // driver tasks
  task automatic tick();
    model_edge();
    @(posedge CLK_I);
    #1;
    check_all();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    ADD_I = a; DAT_I = d; BE = be; WE_I = 1'b1;
    tick();
    WE_I = 1'b0; BE = 4'b0; DAT_I = '0;
  endtask

  task automatic read_expect(input logic [1:0] a, input string tag);
    ADD_I = a;
    #1;
    check(tag, DAT_O, exp_q.pop_front());
  endtask

  initial begin
    RST_I = 1'b1; ADD_I = '0; WE_I = 1'b0; BE = '0; DAT_I = '0; IRQ_SRC = '0; IACK_I = 1'b0;
    m_svc = 0; m_id = 0;
    tick();
    tick();
    RST_I = 1'b0;

    // 1: reset state
    check("rst_irq", 32'(IRQ), 32'd0);
    check("rst_hwint", 32'(HWINT), 32'd0);
    check("rst_id", 32'(IRQ_ID), 32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'(ED)); exp_q.push_back(32'd0);
    read_expect(2'd0, "rst_pend");
    read_expect(2'd1, "rst_mask");
    read_expect(2'd2, "rst_mode");
    read_expect(2'd3, "rst_status");

    // 2: level source 0
    bus_wr(2'd1, 32'h01, 4'b0001);
    IRQ_SRC = 6'h01;
    tick();
    check("lvl_irq_1edge", 32'(IRQ), 32'd0);
    tick();
    check("lvl_irq_2edge", 32'(IRQ), 32'd1);
    check("lvl_id", 32'(IRQ_ID), 32'd0);
    IRQ_SRC = 6'h00;
    tick();
    tick();
    check("lvl_irq_drop", 32'(IRQ), 32'd0);

    // 3: edge source 2, W1C and byte-enable gating
    bus_wr(2'd2, 32'h04, 4'b0001);
    bus_wr(2'd1, 32'h04, 4'b0001);
    IRQ_SRC = 6'h04; tick();
    IRQ_SRC = 6'h00; tick(); tick(); tick();
    exp_q.push_back(32'h04); read_expect(2'd0, "edge_held");
    bus_wr(2'd0, 32'h04, 4'b0001);
    exp_q.push_back(32'h00); read_expect(2'd0, "edge_w1c");
    IRQ_SRC = 6'h04; tick();
    IRQ_SRC = 6'h00; tick(); tick();
    bus_wr(2'd0, 32'h04, 4'b0010);
    exp_q.push_back(32'h04); read_expect(2'd0, "w1c_be_gated");
    bus_wr(2'd0, 32'h04, 4'b0001);

    // 4: priority between level src 1 and edge src 3
    bus_wr(2'd1, 32'h3F, 4'b0001);
    bus_wr(2'd2, 32'h08, 4'b0001);
    IRQ_SRC = 6'h0A; tick(); tick();
    check("prio_1", 32'(IRQ_ID), 32'd1);
    IRQ_SRC = 6'h08; tick(); tick();
    check("prio_3", 32'(IRQ_ID), 32'd3);

    // 5: IACK / service / EOI
    IACK_I = 1'b1; tick(); IACK_I = 1'b0;
    check("svc_irq", 32'(IRQ), 32'd0);
    check("svc_pend3", 32'(HWINT[3]), 32'd0);
    ADD_I = 2'd3; #1;
    check("svc_status9", 32'(DAT_O[9]), 32'd1);
    IRQ_SRC = 6'h00; tick();
    IRQ_SRC = 6'h08; tick(); tick();
    check("svc_new_pend3", 32'(HWINT[3]), 32'd1);
    check("svc_irq_held", 32'(IRQ), 32'd0);
    check("svc_id_frozen", 32'(IRQ_ID), 32'd3);
    bus_wr(2'd3, 32'h0, 4'b0001);
    check("eoi_irq", 32'(IRQ), 32'd1);

    // 6: set beats W1C; reset mid-service
    bus_wr(2'd2, 32'h10, 4'b0001);
    IRQ_SRC = 6'h10; tick();
    bus_wr(2'd0, 32'h10, 4'b0001);
    check("set_wins", 32'(HWINT[4]), 32'd1);
    IACK_I = 1'b1; tick(); IACK_I = 1'b0;
    ADD_I = 2'd3; #1;
    check("svc_again", 32'(DAT_O[9]), 32'd1);
    RST_I = 1'b1; tick(); RST_I = 1'b0;
    check("rst_svc_irq", 32'(IRQ), 32'd0);
    check("rst_svc_hwint", 32'(HWINT), 32'd0);
    exp_q.push_back(32'd0); read_expect(2'd3, "rst_svc_status");
    exp_q.push_back(32'(ED)); read_expect(2'd2, "rst_svc_mode");
    IRQ_SRC = 6'h00;

    // random traffic
    for (int c = 0; c < 600; c++) begin
      IRQ_SRC = IRQ_SRC ^ (6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63)));
      ADD_I   = 2'($urandom_range(0, 3));
      WE_I    = ($urandom_range(0, 3) == 0);
      BE      = 4'($urandom_range(0, 15));
      DAT_I   = $urandom;
      IACK_I  = ($urandom_range(0, 5) == 0);
      RST_I   = ($urandom_range(0, 149) == 0);
      tick();
    end
    WE_I = 1'b0; IACK_I = 1'b0; RST_I = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
